pipe_skid_reg: RTL and testbench

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

---
 rtl/pipe_skid_reg.sv | 100 ++++++++++
 tb/tb_pipe_skid_reg.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with valid/allow-in handshake, optionally extended to a
// two-entry skid buffer so the upstream allow-in comes straight from a flop.
module pipe_skid_reg #(
  parameter int unsigned      WIDTH   = 64,
  parameter int unsigned      SKID    = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             up_valid_i,
  input  logic [WIDTH-1:0] up_bus_i,
  output logic             up_allow_in_o,
  output logic             dn_valid_o,
  output logic [WIDTH-1:0] dn_bus_o,
  input  logic             dn_allow_in_i,
  input  logic             flush_i,
  output logic [1:0]       occ_o
);

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             allow_q, allow_d;
  logic             up_xfer;
  logic             dn_xfer;

  assign up_xfer = up_valid_i && up_allow_in_o;
  assign dn_xfer = dn_valid_o && dn_allow_in_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_EMPTY;
      head_q  <= RST_VAL;
      skid_q  <= RST_VAL;
      allow_q <= 1'b1;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
      allow_q <= allow_d;
    end
  end

  // With SKID=0 the allow-in only opens in ONE alongside a downstream transfer,
  // so FULL and the skid register are never reached.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (flush_i) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (up_xfer) begin
            state_d = ST_ONE;
            head_d  = up_bus_i;
          end
        end
        ST_ONE: begin
          if (up_xfer && dn_xfer) begin
            head_d = up_bus_i;
          end else if (up_xfer) begin
            state_d = ST_FULL;
            skid_d  = up_bus_i;
          end else if (dn_xfer) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (dn_xfer) begin
            state_d = ST_ONE;
            head_d  = skid_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    allow_d = (state_d != ST_FULL);
  end

  always_comb begin
    dn_valid_o = (state_q != ST_EMPTY);
    occ_o      = 2'(state_q);
    dn_bus_o   = head_q;
    if (SKID != 0) begin
      up_allow_in_o = allow_q;
    end else begin
      up_allow_in_o = (state_q == ST_EMPTY) || dn_allow_in_i;
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: both SKID variants share stimulus and are checked
// against queue-based reference models plus a directed vector table.
module tb_pipe_skid_reg;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        up_valid;
  logic [63:0] up_bus;
  logic        dn_allow;

  logic        allow1, dvld1, allow0, dvld0;
  logic [63:0] bus1, bus0;
  logic [1:0]  occ1, occ0;

  int n_chk  = 0;
  int n_pass = 0;

  logic [63:0] q1[$];
  logic [63:0] q0[$];
  bit          mdl_en  = 0;
  bit          sb_on   = 0;
  logic [63:0] sb_next = 64'd0;
  bit          last_ux0 = 0;

  typedef struct {
    bit          rst;
    bit          flush;
    bit          uv;
    logic [63:0] ubus;
    bit          da;
    logic [1:0]  e_occ;
    bit          e_vld;
    bit          e_allow;
    logic [63:0] e_bus;
  } vec_t;

  vec_t tbl[24];

  pipe_skid_reg #(.WIDTH(64), .SKID(1), .RST_VAL(64'd0)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .up_valid_i(up_valid), .up_bus_i(up_bus),
    .up_allow_in_o(allow1), .dn_valid_o(dvld1), .dn_bus_o(bus1),
    .dn_allow_in_i(dn_allow), .flush_i(flush), .occ_o(occ1)
  );

  pipe_skid_reg #(.WIDTH(64), .SKID(0), .RST_VAL(64'd0)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .up_valid_i(up_valid), .up_bus_i(up_bus),
    .up_allow_in_o(allow0), .dn_valid_o(dvld0), .dn_bus_o(bus0),
    .dn_allow_in_i(dn_allow), .flush_i(flush), .occ_o(occ0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic vec_t mk(bit r, bit f, bit uv, logic [63:0] ub, bit da,
                              logic [1:0] eo, bit ev, bit ea, logic [63:0] eb);
    vec_t v;
    v.rst = r; v.flush = f; v.uv = uv; v.ubus = ub; v.da = da;
    v.e_occ = eo; v.e_vld = ev; v.e_allow = ea; v.e_bus = eb;
    return v;
  endfunction

  // One clock cycle: inputs are already applied (at negedge). Outputs are compared
  // to the models, then the models advance with the sampled inputs at posedge.
  task automatic step();
    bit ux0, dx0, ux1, dx1, e_allow0, e_allow1;
    logic [63:0] pb0, pb1;
    #1;
    e_allow1 = (q1.size() < 2);
    e_allow0 = (q0.size() == 0) || dn_allow;
    if (mdl_en) begin
      check("occ1", 64'(occ1), 64'(q1.size()));
      check("vld1", 64'(dvld1), 64'(q1.size() != 0));
      check("allow1", 64'(allow1), 64'(e_allow1));
      if (q1.size() != 0) check("bus1", bus1, q1[0]);
      check("occmax1", 64'(occ1 <= 2'd2), 64'd1);
      if (!allow1) check("allow_full1", 64'(occ1), 64'd2);
      check("occ0", 64'(occ0), 64'(q0.size()));
      check("vld0", 64'(dvld0), 64'(q0.size() != 0));
      check("allow0", 64'(allow0), 64'(e_allow0));
      if (q0.size() != 0) check("bus0", bus0, q0[0]);
      check("occmax0", 64'(occ0 <= 2'd1), 64'd1);
    end
    ux1 = up_valid && e_allow1;
    dx1 = (q1.size() != 0) && dn_allow;
    ux0 = up_valid && e_allow0;
    dx0 = (q0.size() != 0) && dn_allow;
    if (sb_on && dx0 && !rst) begin
      check("sb0", bus0, sb_next);
      sb_next++;
    end
    pb0 = bus0;
    pb1 = bus1;
    @(posedge clk);
    if (rst) begin
      q1.delete();
      q0.delete();
    end else if (flush) begin
      q1.delete();
      q0.delete();
    end else begin
      if (dx1) void'(q1.pop_front());
      if (ux1) q1.push_back(up_bus);
      if (dx0) void'(q0.pop_front());
      if (ux0) q0.push_back(up_bus);
    end
    last_ux0 = ux0 && !rst && !flush;
    @(negedge clk);
    if (mdl_en && !rst) begin
      if (!dvld1) check("hold1", bus1, pb1);
      if (!dvld0) check("hold0", bus0, pb0);
    end
  endtask

  task automatic drive(bit r, bit f, bit uv, logic [63:0] ub, bit da);
    rst = r; flush = f; up_valid = uv; up_bus = ub; dn_allow = da;
  endtask

  initial begin
    drive(1, 0, 0, 64'd0, 0);
    @(negedge clk);
    step();
    mdl_en = 1;

    // rst flush uv bus da | occ vld allow bus (SKID=1 observed this cycle)
    tbl[0]  = mk(1, 0, 0, 64'h0,  0, 2'd0, 0, 1, 64'h0);
    tbl[1]  = mk(0, 0, 1, 64'h1,  1, 2'd0, 0, 1, 64'h0);
    tbl[2]  = mk(0, 0, 1, 64'h2,  1, 2'd1, 1, 1, 64'h1);
    tbl[3]  = mk(0, 0, 1, 64'h3,  1, 2'd1, 1, 1, 64'h2);
    tbl[4]  = mk(0, 0, 0, 64'h0,  1, 2'd1, 1, 1, 64'h3);
    tbl[5]  = mk(0, 0, 0, 64'h0,  0, 2'd0, 0, 1, 64'h3);
    tbl[6]  = mk(0, 0, 1, 64'hA,  0, 2'd0, 0, 1, 64'h3);
    tbl[7]  = mk(0, 0, 1, 64'hB,  0, 2'd1, 1, 1, 64'hA);
    tbl[8]  = mk(0, 0, 1, 64'hC,  0, 2'd2, 1, 0, 64'hA);
    tbl[9]  = mk(0, 0, 0, 64'h0,  1, 2'd2, 1, 0, 64'hA);
    tbl[10] = mk(0, 0, 0, 64'h0,  1, 2'd1, 1, 1, 64'hB);
    tbl[11] = mk(0, 0, 0, 64'h0,  0, 2'd0, 0, 1, 64'hB);
    tbl[12] = mk(0, 0, 1, 64'h11, 0, 2'd0, 0, 1, 64'hB);
    tbl[13] = mk(0, 0, 1, 64'h22, 0, 2'd1, 1, 1, 64'h11);
    tbl[14] = mk(0, 1, 1, 64'h33, 0, 2'd2, 1, 0, 64'h11);
    tbl[15] = mk(0, 0, 0, 64'h0,  1, 2'd0, 0, 1, 64'h11);
    tbl[16] = mk(0, 1, 1, 64'h44, 1, 2'd0, 0, 1, 64'h11);
    tbl[17] = mk(0, 0, 0, 64'h0,  1, 2'd0, 0, 1, 64'h11);
    tbl[18] = mk(0, 0, 1, 64'h55, 0, 2'd0, 0, 1, 64'h11);
    tbl[19] = mk(0, 0, 1, 64'h66, 0, 2'd1, 1, 1, 64'h55);
    tbl[20] = mk(1, 0, 1, 64'h77, 0, 2'd2, 1, 0, 64'h55);
    tbl[21] = mk(0, 0, 1, 64'h88, 1, 2'd0, 0, 1, 64'h0);
    tbl[22] = mk(0, 0, 0, 64'h0,  1, 2'd1, 1, 1, 64'h88);
    tbl[23] = mk(0, 0, 0, 64'h0,  0, 2'd0, 0, 1, 64'h88);

    for (int i = 0; i < 24; i++) begin
      drive(tbl[i].rst, tbl[i].flush, tbl[i].uv, tbl[i].ubus, tbl[i].da);
      #1;
      check($sformatf("t%0d_occ", i), 64'(occ1), 64'(tbl[i].e_occ));
      check($sformatf("t%0d_vld", i), 64'(dvld1), 64'(tbl[i].e_vld));
      check($sformatf("t%0d_allow", i), 64'(allow1), 64'(tbl[i].e_allow));
      check($sformatf("t%0d_bus", i), bus1, tbl[i].e_bus);
      step();
    end

    // Back-to-back stream into the SKID=0 stage with a stuttering consumer.
    drive(0, 1, 0, 64'd0, 0);
    step();
    sb_on   = 1;
    sb_next = 64'd100;
    up_bus  = 64'd100;
    for (int i = 0; i < 400; i++) begin
      rst = 0; flush = 0; up_valid = 1;
      dn_allow = ($urandom_range(0, 2) != 0);
      step();
      if (last_ux0) up_bus = up_bus + 64'd1;
    end
    sb_on = 0;
    check("sb0_progress", 64'(sb_next > 64'd150), 64'd1);

    // Fully random traffic with occasional flush and reset.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 3) != 0), {$urandom, $urandom},
            ($urandom_range(0, 2) != 0));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
